// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if
//   Groups the per-button signals that pass between the button conditioner and
//   its user. Every signal is a vector with one bit per button channel.
//
//   Signals:
//     btn_in      raw asynchronous button inputs, 1 = pressed
//     rpt_en      per-channel auto-repeat enable, synchronous to clk
//     btn_level   debounced, registered button state
//     btn_press   one-cycle strobe on debounced press and on each repeat
//     btn_release one-cycle strobe on debounced release
//
//   Handshake: there is no valid/ready pair on this bus. btn_press and
//   btn_release are single-cycle strobes with no backpressure; a consumer
//   must act on each strobe in the cycle it is high. btn_level is a plain level.
//
//   Modports:
//     master  drives btn_in/rpt_en, observes the conditioned outputs
//     slave   the conditioner itself
interface btn_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] rpt_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_in,
    output rpt_en,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    input  rpt_en,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Push-button front end for the digital-clock core. Each of N_BTN channels
//   is independently synchronised (two flops), debounced, and turned into a
//   registered level plus one-cycle press/release strobes. With auto-repeat
//   compiled in, a held button emits further press strobes: the first one
//   HOLD_CYC cycles after the initial press, then one every RPT_CYC cycles.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     defined   : HOLD/RPT repeat logic and repeat counter are built;
//                 rpt_en gates repeating per channel.
//     undefined : press strobes only on the debounced rising edge; rpt_en
//                 is accepted but ignored.
//
//   Ports:
//     clk        system clock
//     clr        synchronous active-high reset
//     bus        btn_conditioner_if.slave (btn_in, rpt_en in;
//                btn_level, btn_press, btn_release out)
//     dbg_state  per-channel FSM state, channel i at [2*i +: 2]
//                (0 = IDLE, 1 = HOLD, 2 = RPT)
module btn_conditioner #(
  parameter int N_BTN    = 4,
  parameter int DB_CYC   = 500_000,
  parameter int HOLD_CYC = 25_000_000,
  parameter int RPT_CYC  = 5_000_000
) (
  input  logic                 clk,
  input  logic                 clr,
  btn_conditioner_if.slave     bus,
  output logic [2*N_BTN-1:0]   dbg_state
);

  localparam int DW   = $clog2(DB_CYC + 1);
  localparam int RMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
  } state_t;
`endif

  // Synchroniser and debounce state
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] s;
  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] lvl_d;
  logic [DW-1:0]    db_cnt   [N_BTN];
  logic [DW-1:0]    db_cnt_d [N_BTN];
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  // FSM state and registered strobes
  state_t           state   [N_BTN];
  state_t           state_d [N_BTN];
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] release_d;

`ifdef BTN_AUTOREPEAT_EN
  logic [RW-1:0]    rcnt   [N_BTN];
  logic [RW-1:0]    rcnt_d [N_BTN];
`else
  // Repeat configuration and rpt_en are deliberately unused in this build.
  logic [RW-1:0]    unused_rpt_cfg;
  logic [N_BTN-1:0] unused_rpt_en;
  assign unused_rpt_cfg = RW'(HOLD_CYC) ^ RW'(RPT_CYC);
  assign unused_rpt_en  = bus.rpt_en;
`endif

  // Debounce: the counter holds the number of consecutive mismatched
  // samples already seen. The level flips on the edge where the synchronised
  // input is still mismatched with DB_CYC prior mismatches counted, i.e. after
  // DB_CYC+1 stable samples; with the two sync flops this puts the level
  // change DB_CYC+2 edges after a clean input edge.
  always_comb begin
    lvl_d = lvl;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (s[i] != lvl[i]) begin
        if (db_cnt[i] == DW'(DB_CYC)) begin
          lvl_d[i] = ~lvl[i];
        end else begin
          db_cnt_d[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = lvl_d & ~lvl;
  assign fall = lvl & ~lvl_d;

  // Per-channel FSM next state. Strobes are computed from the level change
  // happening on this edge so they register together with btn_level.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state[i];
`ifdef BTN_AUTOREPEAT_EN
      rcnt_d[i]  = rcnt[i];
`endif
      case (state[i])
        ST_IDLE: begin
          if (rise[i]) begin
            press_d[i] = 1'b1;
            state_d[i] = ST_HOLD;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_d[i]  = '0;
`endif
          end
        end
        ST_HOLD: begin
          // Release wins over a repeat due on the same edge.
          if (fall[i]) begin
            release_d[i] = 1'b1;
            state_d[i]   = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_d[i]    = '0;
          end else if (!bus.rpt_en[i]) begin
            rcnt_d[i]    = '0;
          end else if (rcnt[i] == RW'(HOLD_CYC - 1)) begin
            press_d[i]   = 1'b1;
            rcnt_d[i]    = '0;
            state_d[i]   = ST_RPT;
          end else begin
            rcnt_d[i]    = rcnt[i] + 1'b1;
`endif
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        ST_RPT: begin
          if (fall[i]) begin
            release_d[i] = 1'b1;
            state_d[i]   = ST_IDLE;
            rcnt_d[i]    = '0;
          end else if (!bus.rpt_en[i]) begin
            // Disabling drops back to HOLD so re-enabling waits HOLD_CYC again.
            rcnt_d[i]    = '0;
            state_d[i]   = ST_HOLD;
          end else if (rcnt[i] == RW'(RPT_CYC - 1)) begin
            press_d[i]   = 1'b1;
            rcnt_d[i]    = '0;
          end else begin
            rcnt_d[i]    = rcnt[i] + 1'b1;
          end
        end
`endif
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1     <= '0;
      s         <= '0;
      lvl       <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
        state[i]  <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
        rcnt[i]   <= '0;
`endif
      end
    end else begin
      sync1     <= bus.btn_in;
      s         <= sync1;
      lvl       <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= db_cnt_d[i];
        state[i]  <= state_d[i];
`ifdef BTN_AUTOREPEAT_EN
        rcnt[i]   <= rcnt_d[i];
`endif
      end
    end
  end

  assign bus.btn_level   = lvl;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dbg_state[2*i +: 2] = state[i];
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//   Drives btn_conditioner through directed scenarios (bounce, auto-repeat,
//   release during repeat, rpt_en gating, reset mid-repeat, simultaneous
//   channels) followed by a randomised phase. A reference model built on
//   per-channel sample history and repeat due-times predicts the outputs of
//   every cycle; predictions go through an expected queue and are compared
//   each negative edge. Works with or without BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;
  localparam int N_BTN    = 4;
  localparam int DB_CYC   = 4;
  localparam int HOLD_CYC = 20;
  localparam int RPT_CYC  = 8;
  localparam int W        = 3 * N_BTN;
  // Input driven just after edge t is first sampled on edge t+1 ("edge 0");
  // the level changes on edge 0 + DB_CYC + 2.
  localparam int LAT      = DB_CYC + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  logic [2*N_BTN-1:0] dbg_state;

  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(N_BTN)) bus ();

  btn_conditioner #(
    .N_BTN   (N_BTN),
    .DB_CYC  (DB_CYC),
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Level rule: flip when the last DB_CYC+1 synchronised samples all differ
  // from the current level; the synchroniser lags the raw input by 2 samples.
  // Repeat rule: a press is due at anchor+period while held and enabled.
  logic [W-1:0] exp_q[$];
  bit           hist   [N_BTN][$];
  bit           lvl_m  [N_BTN];
  int           anchor [N_BTN];
  int           period [N_BTN];

  always @(posedge clk) begin
    logic [N_BTN-1:0] l, p, r;
    bit flip;
    cyc = cyc + 1;
    l = '0;
    p = '0;
    r = '0;
    for (int c = 0; c < N_BTN; c++) begin
      if (clr) begin
        hist[c].delete();
        for (int k = 0; k < DB_CYC + 3; k++) hist[c].push_back(1'b0);
        lvl_m[c]  = 1'b0;
        anchor[c] = 0;
        period[c] = HOLD_CYC;
      end else begin
        hist[c].push_back(bus.btn_in[c]);
        if (hist[c].size() > DB_CYC + 3) void'(hist[c].pop_front());
        // indices 0..DB_CYC are the samples from edges e-2-DB_CYC .. e-2
        flip = 1'b1;
        for (int k = 0; k <= DB_CYC; k++) begin
          if (hist[c][k] == lvl_m[c]) flip = 1'b0;
        end
        if (flip) begin
          lvl_m[c] = ~lvl_m[c];
          if (lvl_m[c]) begin
            p[c]      = 1'b1;
            anchor[c] = cyc;
            period[c] = HOLD_CYC;
          end else begin
            r[c] = 1'b1;
          end
        end else if (lvl_m[c]) begin
`ifdef BTN_AUTOREPEAT_EN
          if (!bus.rpt_en[c]) begin
            anchor[c] = cyc;
            period[c] = HOLD_CYC;
          end else if (cyc == anchor[c] + period[c]) begin
            p[c]      = 1'b1;
            anchor[c] = cyc;
            period[c] = RPT_CYC;
          end
`endif
        end
      end
      l[c] = lvl_m[c];
    end
    exp_q.push_back({l, p, r});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("level",   32'(bus.btn_level),   32'(e[3*N_BTN-1 -: N_BTN]));
      check("press",   32'(bus.btn_press),   32'(e[2*N_BTN-1 -: N_BTN]));
      check("release", 32'(bus.btn_release), 32'(e[N_BTN-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input int c, input logic val, input int bound,
                            output int e, output bit ok);
    ok = 1'b0;
    e  = -1;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (bus.btn_level[c] === val) begin
        ok = 1'b1;
        e  = cyc;
      end
    end
  endtask

  task automatic wait_press(input int c, input int bound, output int e, output bit ok);
    ok = 1'b0;
    e  = -1;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (bus.btn_press[c] === 1'b1) begin
        ok = 1'b1;
        e  = cyc;
      end
    end
  endtask

  task automatic count_press(input int c, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.btn_press[c] === 1'b1) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, e, n;
    bit ok;
    int hold_left[N_BTN];

    bus.btn_in = '0;
    bus.rpt_en = '0;
    clr        = 1'b1;
    tick(3);
    clr = 1'b0;
    check("reset_level",   32'(bus.btn_level),   32'd0);
    check("reset_press",   32'(bus.btn_press),   32'd0);
    check("reset_release", 32'(bus.btn_release), 32'd0);

    // 1: bounce on channel 0, then a clean hold
    bus.rpt_en = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      bus.btn_in[0] = ~bus.btn_in[0];
      tick(2);
    end
    bus.btn_in[0] = 1'b1;
    t = cyc;
    wait_level(0, 1'b1, 20, e, ok);
    check("s1_rise_seen", 32'(ok), 32'd1);
    check("s1_rise_edge", 32'(e), 32'(t + LAT));
    check("s1_press_with_rise", 32'(bus.btn_press[0]), 32'd1);

    // 2: keep holding for 80 cycles after the rise
    count_press(0, 80, n);
`ifdef BTN_AUTOREPEAT_EN
    check("s2_repeat_count", 32'(n), 32'd8);
`else
    check("s2_repeat_count", 32'(n), 32'd0);
`endif

    // 3: release timed so the level falls on an edge where a repeat is due
    tick(5);
    bus.btn_in[0] = 1'b0;
    t = cyc;
    wait_level(0, 1'b0, 20, e, ok);
    check("s3_fall_seen", 32'(ok), 32'd1);
    check("s3_fall_edge", 32'(e), 32'(t + LAT));
    check("s3_release_pulse", 32'(bus.btn_release[0]), 32'd1);
    check("s3_no_press_on_fall", 32'(bus.btn_press[0]), 32'd0);
    count_press(0, 12, n);
    check("s3_no_press_after", 32'(n), 32'd0);

    // 4: channel 1 held with repeat disabled, then enabled
    bus.rpt_en[1] = 1'b0;
    bus.btn_in[1] = 1'b1;
    wait_level(1, 1'b1, 20, e, ok);
    check("s4_rise_seen", 32'(ok), 32'd1);
    check("s4_press_with_rise", 32'(bus.btn_press[1]), 32'd1);
    count_press(1, 60, n);
    check("s4_no_repeat_disabled", 32'(n), 32'd0);
    bus.rpt_en[1] = 1'b1;
    t = cyc;
    wait_press(1, 40, e, ok);
`ifdef BTN_AUTOREPEAT_EN
    check("s4_repeat_seen", 32'(ok), 32'd1);
    check("s4_repeat_edge", 32'(e), 32'(t + HOLD_CYC));
`else
    check("s4_repeat_seen", 32'(ok), 32'd0);
`endif

    // 5: reset while channel 0 is repeating and still held
    bus.rpt_en[0] = 1'b1;
    bus.btn_in[0] = 1'b1;
    wait_level(0, 1'b1, 20, e, ok);
    check("s5_rise_seen", 32'(ok), 32'd1);
    tick(30);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    t = cyc;
    check("s5_level_cleared",   32'(bus.btn_level),   32'd0);
    check("s5_press_cleared",   32'(bus.btn_press),   32'd0);
    check("s5_release_cleared", 32'(bus.btn_release), 32'd0);
    wait_press(0, 20, e, ok);
    check("s5_press_seen", 32'(ok), 32'd1);
    check("s5_press_edge", 32'(e), 32'(t + LAT));

    // 6: channels 2 and 3 pressed on the same cycle
    bus.btn_in = '0;
    bus.rpt_en = '0;
    tick(15);
    bus.btn_in[2] = 1'b1;
    bus.btn_in[3] = 1'b1;
    t = cyc;
    wait_press(2, 20, e, ok);
    check("s6_press2_seen", 32'(ok), 32'd1);
    check("s6_press2_edge", 32'(e), 32'(t + LAT));
    check("s6_press3_same_edge", 32'(bus.btn_press[3]), 32'd1);
    bus.btn_in = '0;
    tick(15);

    // random phase: mixed glitches and long holds, rpt_en toggling, rare reset
    for (int c = 0; c < N_BTN; c++) hold_left[c] = $urandom_range(1, 40);
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < N_BTN; c++) begin
        if (hold_left[c] == 0) begin
          bus.btn_in[c] = ~bus.btn_in[c];
          hold_left[c]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                      : $urandom_range(6, 70);
        end else begin
          hold_left[c]--;
        end
        if ($urandom_range(0, 63) == 0) bus.rpt_en[c] = ~bus.rpt_en[c];
      end
      clr = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    clr        = 1'b0;
    bus.btn_in = '0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
